// File: rtl/axis_crc16_check.sv
// AXI-Stream CRC-16/USB frame checker: strips the trailing 2-byte FCS (low byte first),
// forwards the payload, and flags a CRC mismatch or upstream error on the last payload beat.
module axis_crc16_check #(
  parameter logic [15:0] CRC_INIT   = 16'hFFFF,
  parameter logic [15:0] CRC_XOROUT = 16'hFFFF,
  parameter int unsigned DROP_RUNT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_crc_err,
  output logic       stat_runt,
  output logic       stat_frame_ok
);

  typedef enum logic [1:0] {FILL_EMPTY, FILL_ONE, FILL_TWO} fill_e;

  fill_e       r_fill, w_fill_next;
  logic [7:0]  r_h0, r_h1, r_mdata;
  logic        r_mvalid, r_mlast, r_muser, r_err;
  logic        r_stat_crc_err, r_stat_runt, r_stat_ok;
  logic [15:0] r_crc, w_crc_h0, w_crc_final;
  logic        w_ready, w_acc, w_push, w_close, w_runt, w_mismatch, w_err;

  // Reflected CRC-16 (poly 0xA001), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_fill <= FILL_EMPTY;
    else     r_fill <= w_fill_next;
  end

  always_comb begin
    w_fill_next = r_fill;
    if (w_acc) begin
      if (s_axis_tlast) begin
        w_fill_next = FILL_EMPTY;
      end else begin
        unique case (r_fill)
          FILL_EMPTY: w_fill_next = FILL_ONE;
          FILL_ONE:   w_fill_next = FILL_TWO;
          default:    w_fill_next = FILL_TWO;
        endcase
      end
    end
  end

  always_comb begin
    w_ready     = !r_mvalid || m_axis_tready;
    w_acc       = s_axis_tvalid && w_ready;
    w_push      = w_acc && !s_axis_tlast && (r_fill == FILL_TWO);
    w_close     = w_acc &&  s_axis_tlast && (r_fill == FILL_TWO);
    w_runt      = w_acc &&  s_axis_tlast && (r_fill != FILL_TWO);
    // h0 is the final payload byte on close, so it is folded in before comparing with {b, h1}.
    w_crc_h0    = crc16_byte(r_crc, r_h0);
    w_crc_final = w_crc_h0 ^ CRC_XOROUT;
    w_mismatch  = w_crc_final != {s_axis_tdata, r_h1};
    w_err       = r_err || s_axis_tuser;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mvalid       <= 1'b0;
      r_mdata        <= '0;
      r_mlast        <= 1'b0;
      r_muser        <= 1'b0;
      r_h0           <= '0;
      r_h1           <= '0;
      r_crc          <= CRC_INIT;
      r_err          <= 1'b0;
      r_stat_crc_err <= 1'b0;
      r_stat_runt    <= 1'b0;
      r_stat_ok      <= 1'b0;
    end else begin
      r_stat_crc_err <= 1'b0;
      r_stat_runt    <= 1'b0;
      r_stat_ok      <= 1'b0;
      if (m_axis_tready) r_mvalid <= 1'b0;
      if (w_acc) begin
        if (s_axis_tlast) begin
          r_crc <= CRC_INIT;
          r_err <= 1'b0;
        end else begin
          r_err <= w_err;
          unique case (r_fill)
            FILL_EMPTY: r_h0 <= s_axis_tdata;
            FILL_ONE:   r_h1 <= s_axis_tdata;
            default: begin
              r_h0 <= r_h1;
              r_h1 <= s_axis_tdata;
            end
          endcase
        end
      end
      if (w_push) begin
        r_mvalid <= 1'b1;
        r_mdata  <= r_h0;
        r_mlast  <= 1'b0;
        r_muser  <= 1'b0;
        r_crc    <= w_crc_h0;
      end
      if (w_close) begin
        r_mvalid       <= 1'b1;
        r_mdata        <= r_h0;
        r_mlast        <= 1'b1;
        r_muser        <= w_mismatch || w_err;
        r_stat_crc_err <= w_mismatch;
        r_stat_ok      <= !w_mismatch && !w_err;
      end
      if (w_runt) begin
        r_stat_runt <= 1'b1;
        if (DROP_RUNT == 0) begin
          r_mvalid <= 1'b1;
          r_mdata  <= 8'h00;
          r_mlast  <= 1'b1;
          r_muser  <= 1'b1;
        end
      end
    end
  end

  assign s_axis_tready = w_ready;
  assign m_axis_tdata  = r_mdata;
  assign m_axis_tvalid = r_mvalid;
  assign m_axis_tlast  = r_mlast;
  assign m_axis_tuser  = r_muser;
  assign stat_crc_err  = r_stat_crc_err;
  assign stat_runt     = r_stat_runt;
  assign stat_frame_ok = r_stat_ok;

endmodule

// File: tb/tb_axis_crc16_check.sv
// Directed and randomized frame bench for axis_crc16_check (drop-runt and keep-runt instances).
module tb_axis_crc16_check;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tuser;
  logic       m_tready = 1'b1;
  logic       st_err, st_runt, st_ok;

  logic [7:0] b_tdata = 8'h00;
  logic       b_tvalid = 1'b0, b_tlast = 1'b0;
  logic       b_tready;
  logic [7:0] b_mdata;
  logic       b_mvalid, b_mlast, b_muser;
  logic       b_st_err, b_st_runt, b_st_ok;

  axis_crc16_check #(.DROP_RUNT(1)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .stat_crc_err(st_err), .stat_runt(st_runt), .stat_frame_ok(st_ok)
  );

  axis_crc16_check #(.DROP_RUNT(0)) u_dut_keep (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .s_axis_tlast(b_tlast), .s_axis_tuser(1'b0),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(1'b1),
    .m_axis_tlast(b_mlast), .m_axis_tuser(b_muser),
    .stat_crc_err(b_st_err), .stat_runt(b_st_runt), .stat_frame_ok(b_st_ok)
  );

  int vectors = 0, miscompares = 0, timeouts = 0;
  int n_ok = 0, n_err = 0, n_runt = 0, n1_runt = 0, n1_other = 0;
  logic [9:0] q0[$], q1[$], exp_q[$];
  logic [7:0] frm[$];
  bit rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) q0.push_back({m_tlast, m_tuser, m_tdata});
      if (b_mvalid) q1.push_back({b_mlast, b_muser, b_mdata});
      if (st_ok) n_ok++;
      if (st_err) n_err++;
      if (st_runt) n_runt++;
      if (b_st_runt) n1_runt++;
      if (b_st_err || b_st_ok) n1_other++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic u, input bit gaps);
    int unsigned guard;
    if (gaps) while ($urandom_range(0, 2) == 0) begin
      s_tvalid = 1'b0;
      @(negedge clk);
    end
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    #1;
    guard = 0;
    while (!s_tready && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) timeouts++;
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic send_frame(input int user_at, input bit gaps);
    for (int i = 0; i < frm.size(); i++)
      send_byte(frm[i], i == frm.size() - 1, i == user_at, gaps);
  endtask

  task automatic load_good();
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
    frm.push_back(8'hC8);
    frm.push_back(8'hB4);
  endtask

  task automatic exp_append(input logic ul);
    int n;
    n = frm.size();
    for (int i = 0; i < n - 2; i++)
      exp_q.push_back({i == n - 3, ul && (i == n - 3), frm[i]});
  endtask

  task automatic check_out(input string tag, input int base);
    int n;
    n = q0.size() - base;
    check({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check(tag, {22'h0, q0[base + i]}, {22'h0, exp_q[i]});
  endtask

  initial begin
    int b, bo, be, br, nl, len, bad, e_ok, e_err, e_runt;
    logic [15:0] c;
    logic [7:0] rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mvalid", m_tvalid, 0);
    check("rst_mlast", m_tlast, 0);
    check("rst_muser", m_tuser, 0);
    check("rst_mdata", m_tdata, 0);
    check("rst_stats", {st_err, st_runt, st_ok}, 0);
    check("rst_sready", s_tready, 1);
    check("rst_keep_sready", b_tready, 1);
    @(negedge clk);

    // Good "123456789" frame
    load_good();
    b = q0.size(); bo = n_ok; be = n_err; br = n_runt;
    exp_q.delete(); exp_append(1'b0);
    send_frame(-1, 1'b0);
    repeat (5) @(negedge clk);
    check_out("good", b);
    check("good_ok", n_ok - bo, 1);
    check("good_err", n_err - be, 0);

    // Corrupted FCS
    load_good();
    frm[10] = 8'hB5;
    b = q0.size(); bo = n_ok; be = n_err;
    exp_q.delete(); exp_append(1'b1);
    send_frame(-1, 1'b0);
    repeat (5) @(negedge clk);
    check_out("badfcs", b);
    check("badfcs_err", n_err - be, 1);
    check("badfcs_ok", n_ok - bo, 0);

    // Minimal 3-byte frame back-to-back with the 11-byte good frame
    b = q0.size(); bo = n_ok; be = n_err;
    exp_q.delete();
    frm.delete(); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'hBF);
    exp_append(1'b0);
    send_frame(-1, 1'b0);
    load_good();
    exp_append(1'b0);
    send_frame(-1, 1'b0);
    repeat (5) @(negedge clk);
    check_out("b2b", b);
    check("b2b_ok", n_ok - bo, 2);
    check("b2b_err", n_err - be, 0);

    // Runt AA BB, dropped
    frm.delete(); frm.push_back(8'hAA); frm.push_back(8'hBB);
    b = q0.size(); bo = n_ok; be = n_err; br = n_runt;
    send_frame(-1, 1'b0);
    repeat (5) @(negedge clk);
    check("runt_drop_beats", q0.size() - b, 0);
    check("runt_drop_stat", n_runt - br, 1);
    check("runt_drop_other", (n_ok - bo) + (n_err - be), 0);

    // Runt AA BB, kept as a single error beat
    b_tdata = 8'hAA; b_tvalid = 1'b1; b_tlast = 1'b0;
    @(negedge clk);
    b_tdata = 8'hBB; b_tlast = 1'b1;
    @(negedge clk);
    b_tvalid = 1'b0; b_tlast = 1'b0;
    repeat (5) @(negedge clk);
    check("runt_keep_beats", q1.size(), 1);
    if (q1.size() > 0) check("runt_keep_beat", {22'h0, q1[0]}, {22'h0, 10'h300});
    check("runt_keep_stat", n1_runt, 1);
    check("runt_keep_other", n1_other, 0);

    // Upstream error on byte 4 of a good frame
    load_good();
    b = q0.size(); bo = n_ok; be = n_err;
    exp_q.delete(); exp_append(1'b1);
    send_frame(3, 1'b0);
    repeat (5) @(negedge clk);
    check_out("uerr", b);
    check("uerr_ok", n_ok - bo, 0);
    check("uerr_crcerr", n_err - be, 0);

    // Reset mid-frame, then a clean frame
    load_good();
    b = q0.size(); bo = n_ok; be = n_err; br = n_runt;
    for (int i = 0; i < 5; i++) send_byte(frm[i], 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_mvalid", m_tvalid, 0);
    check("midrst_sready", s_tready, 1);
    @(negedge clk);
    nl = 0;
    for (int i = b; i < q0.size(); i++) if (q0[i][9]) nl++;
    check("midrst_no_tlast", nl, 0);
    check("midrst_no_stat", (n_ok - bo) + (n_err - be) + (n_runt - br), 0);
    b = q0.size(); bo = n_ok;
    exp_q.delete(); exp_append(1'b0);
    send_frame(-1, 1'b0);
    repeat (5) @(negedge clk);
    check_out("postrst", b);
    check("postrst_ok", n_ok - bo, 1);

    // Random frames with source gaps and sink backpressure
    rand_ready = 1'b1;
    b = q0.size(); bo = n_ok; be = n_err; br = n_runt;
    e_ok = 0; e_err = 0; e_runt = 0;
    exp_q.delete();
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 64);
      frm.delete();
      if (len < 3) begin
        for (int k = 0; k < len; k++) frm.push_back(8'($urandom_range(0, 255)));
        e_runt++;
      end else begin
        c = 16'hFFFF;
        for (int k = 0; k < len - 2; k++) begin
          rb = 8'($urandom_range(0, 255));
          frm.push_back(rb);
          c = crc16(c, rb);
        end
        c = c ^ 16'hFFFF;
        bad = ($urandom_range(0, 3) == 0) ? 1 : 0;
        if (bad != 0) begin
          c[0] = ~c[0];
          e_err++;
        end else begin
          e_ok++;
        end
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        exp_append(bad != 0);
      end
      send_frame(-1, 1'b1);
    end
    @(posedge clk);
    rand_ready = 1'b0;
    repeat (20) @(negedge clk);
    check_out("rand", b);
    check("rand_ok", n_ok - bo, e_ok);
    check("rand_err", n_err - be, e_err);
    check("rand_runt", n_runt - br, e_runt);
    check("timeouts", timeouts, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
